// File: rtl/cla_nibble_seq_adder_if.sv
// cla_nibble_seq_adder_if: operand/result valid-ready bundle for the nibble-serial CLA adder.
// SUB is present only when CLA_SEQ_SUB_EN is defined.
interface cla_nibble_seq_adder_if #(parameter int WIDTH = 16);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;
`ifdef CLA_SEQ_SUB_EN
    logic             sub;
    modport master (output in_valid, a, b, cin, sub, out_ready,
                    input  in_ready, out_valid, sum, cout, busy);
    modport slave  (input  in_valid, a, b, cin, sub, out_ready,
                    output in_ready, out_valid, sum, cout, busy);
`else
    modport master (output in_valid, a, b, cin, out_ready,
                    input  in_ready, out_valid, sum, cout, busy);
    modport slave  (input  in_valid, a, b, cin, out_ready,
                    output in_ready, out_valid, sum, cout, busy);
`endif
endinterface

// File: rtl/cla_nibble_seq_adder.sv
// cla_nibble_seq_adder: WIDTH-bit add through one 4-bit CLA slice, one nibble per clock, LSB first.
// Optional CLA_SEQ_SUB_EN adds SUB (A-B via ~B and carry-in 1).
module cla_nibble_seq_adder #(
    parameter int WIDTH = 16
) (
    input logic                   i_clk,
    input logic                   i_rst_n,
    cla_nibble_seq_adder_if.slave bus
);
    localparam int NIBS = WIDTH / 4;
    localparam int CW   = NIBS > 1 ? $clog2(NIBS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_a, r_b, r_sum;
    logic             r_carry, r_cout, r_out_valid, r_in_ready, r_busy;
    logic [WIDTH-1:0] w_b_ld;
    logic             w_c_ld;
    logic [3:0]       w_a, w_b, w_g, w_p, w_s;
    logic [4:0]       w_c;

`ifdef CLA_SEQ_SUB_EN
    assign w_b_ld = bus.sub ? ~bus.b : bus.b;
    assign w_c_ld = bus.sub | bus.cin;
`else
    assign w_b_ld = bus.b;
    assign w_c_ld = bus.cin;
`endif

    assign w_a = r_a[4*r_cnt +: 4];
    assign w_b = r_b[4*r_cnt +: 4];
    assign w_g = w_a & w_b;
    assign w_p = w_a ^ w_b;
    // Fully expanded lookahead carries: no carry depends on another computed carry
    assign w_c[0] = r_carry;
    assign w_c[1] = w_g[0] | (w_p[0] & r_carry);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & r_carry);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & r_carry);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & r_carry);
    assign w_s    = w_p ^ w_c[3:0];

    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_sum       <= '0;
            r_carry     <= 1'b0;
            r_cout      <= 1'b0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b0;
            r_busy      <= 1'b0;
        end else
            case (r_state)
                IDLE: begin
                    r_in_ready <= 1'b1;
                    if (bus.in_valid && r_in_ready) begin
                        r_a        <= bus.a;
                        r_b        <= w_b_ld;
                        r_carry    <= w_c_ld;
                        r_cnt      <= '0;
                        r_sum      <= '0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= RUN;
                    end
                end
                RUN: begin
                    r_sum[4*r_cnt +: 4] <= w_s;
                    r_carry             <= w_c[4];
                    if (r_cnt == CW'(NIBS - 1)) begin
                        r_cout  <= w_c[4];
                        r_state <= DONE;
                    end else
                        r_cnt <= r_cnt + 1'b1;
                end
                DONE: begin
                    // Valid rises on the first DONE cycle; the handshake needs it already high
                    r_out_valid <= 1'b1;
                    if (r_out_valid && bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.sum       = r_sum;
    assign bus.cout      = r_cout;
    assign bus.busy      = r_busy;
endmodule
